// File: rtl/pwm_pkg.sv
// Shared types and move arithmetic for the PWM duty soft-start/soft-stop ramp.
// Combinational only; no latency or backpressure.
package pwm_pkg;
    localparam int DUTY_W_DFLT = 6;
    localparam int DIV_W_DFLT  = 8;
    // Helper width; callers zero-extend narrower duty words into it.
    localparam int SAT_W       = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // One saturating move toward tgt, evaluated with a spare bit so it never wraps.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] duty,
        input logic [SAT_W-1:0] tgt,
        input logic [SAT_W-1:0] stp
    );
        logic [SAT_W:0]   w_sum;
        logic [SAT_W-1:0] w_res;
        w_sum = {1'b0, duty} + {1'b0, stp};
        w_res = duty;
        if (duty < tgt) begin
            w_res = (w_sum >= {1'b0, tgt}) ? tgt : w_sum[SAT_W-1:0];
        end else if (duty > tgt) begin
            w_res = ((duty - tgt) <= stp) ? tgt : (duty - stp);
        end
        return w_res;
    endfunction
endpackage

// File: rtl/pwm_ramp_divider.sv
// Ramp-rate divider: counts period_end strobes, ticks on every (div+1)-th one.
// Tick is combinational with the enabling strobe; no backpressure.
module pwm_ramp_divider
    import pwm_pkg::*;
#(
    parameter int DIV_W = DIV_W_DFLT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == i_div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start/soft-stop sequencer stepping the PWM duty word toward a latched target on period wraps.
// Busy 1 cycle after start; first move on the (div+1)-th period_end; no backpressure.
module pwm_duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DFLT,
    parameter int DIV_W  = DIV_W_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DUTY_W-1:0] i_target,
    input  logic [DUTY_W-1:0] i_step,
    input  logic [DIV_W-1:0]  i_rate_div,
    input  logic              i_period_end,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_busy,
    output logic              o_done
);
    ramp_state_t       r_state;
    logic [DUTY_W-1:0] r_duty;
    logic              r_done;
    logic [DUTY_W-1:0] r_tgt;
    logic [DUTY_W-1:0] r_stp;
    logic [DIV_W-1:0]  r_div;

    ramp_state_t       w_state_nxt;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] w_move;
    logic              w_done_nxt;
    logic              w_latch;
    logic              w_clr;
    logic              w_div_en;
    logic              w_tick;

    // Strobes only count while ramping and when no higher-priority request is present.
    assign w_div_en = (r_state == RAMP) && i_period_end && !i_start && !i_abort;

    pwm_ramp_divider #(.DIV_W(DIV_W)) u_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_div_en),
        .i_div   (r_div),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_move      = DUTY_W'(sat_step(SAT_W'(r_duty), SAT_W'(r_tgt), SAT_W'(r_stp)));
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_clr       = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
        end else if (i_start) begin
            w_latch = 1'b1;
            w_clr   = 1'b1;
            if (i_target == r_duty) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = RAMP;
            end
        end else if (w_tick) begin
            w_duty_nxt = w_move;
            if (w_move == r_tgt) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_done  <= 1'b0;
            r_tgt   <= '0;
            r_stp   <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_tgt <= i_target;
                r_stp <= (i_step == '0) ? DUTY_W'(1) : i_step;
                r_div <= i_rate_div;
            end
        end
    end

    assign o_duty = r_duty;
    assign o_busy = (r_state == RAMP);
    assign o_done = r_done;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl: expected duty moves and done pulses are queued
// with each stimulus and retired by a monitor sampling 1 time unit after each rising edge.
module tb_pwm_duty_ramp_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [5:0] target;
    logic [5:0] step;
    logic [7:0] rate_div;
    logic       period_end;
    logic [5:0] duty;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] exp_duty_q[$];
    logic [5:0] exp_done_q[$];

    pwm_duty_ramp_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_target     (target),
        .i_step       (step),
        .i_rate_div   (rate_div),
        .i_period_end (period_end),
        .o_duty       (duty),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_start(input int t, input int s, input int d, input logic with_pe);
        @(negedge clk);
        start      = 1'b1;
        target     = 6'(t);
        step       = 6'(s);
        rate_div   = 8'(d);
        period_end = with_pe;
        @(negedge clk);
        start      = 1'b0;
        period_end = 1'b0;
        target     = 6'h2a;
        step       = 6'h15;
        rate_div   = 8'hff;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (63) @(negedge clk);
            period_end = 1'b1;
            @(negedge clk);
            period_end = 1'b0;
        end
    endtask

    // Monitor: every duty change must be the next queued value and land on a period_end edge.
    initial begin : monitor
        logic [5:0] prev_duty;
        logic [5:0] e;
        prev_duty = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_duty = duty;
            end else begin
                if (duty != prev_duty) begin
                    chk("duty_chg_on_pe", int'(period_end), 1);
                    if (exp_duty_q.size() == 0) begin
                        chk("duty_unexpected", int'(duty), int'(prev_duty));
                    end else begin
                        e = exp_duty_q.pop_front();
                        chk("duty_move", int'(duty), int'(e));
                    end
                    prev_duty = duty;
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        e = exp_done_q.pop_front();
                        chk("done_duty", int'(duty), int'(e));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; period_end = 1'b0;
        target = '0; step = '0; rate_div = '0;
        repeat (3) @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // 1: ramp up 0 -> 40 in steps of 8, one move per period
        exp_duty_q.push_back(8); exp_duty_q.push_back(16); exp_duty_q.push_back(24);
        exp_duty_q.push_back(32); exp_duty_q.push_back(40); exp_done_q.push_back(40);
        do_start(40, 8, 0, 1'b0);
        chk("t1_busy_after_start", int'(busy), 1);
        strobes(5);
        chk("t1_busy_low", int'(busy), 0);
        chk("t1_duty_final", int'(duty), 40);
        chk("t1_done_consumed", exp_done_q.size(), 0);

        // 2: ramp down 40 -> 3, step 10, one move every 3rd period
        exp_duty_q.push_back(30); exp_duty_q.push_back(20); exp_duty_q.push_back(10);
        exp_duty_q.push_back(3); exp_done_q.push_back(3);
        do_start(3, 10, 2, 1'b0);
        strobes(2);
        chk("t2_hold_two_strobes", int'(duty), 40);
        strobes(10);
        chk("t2_duty_final", int'(duty), 3);
        strobes(2);
        chk("t2_idle_ignores_pe", int'(duty), 3);

        // 3: reach 60, then 60 -> 63 with step 7 saturates at max
        exp_duty_q.push_back(60); exp_done_q.push_back(60);
        do_start(60, 57, 0, 1'b0);
        strobes(1);
        exp_duty_q.push_back(63); exp_done_q.push_back(63);
        do_start(63, 7, 0, 1'b0);
        strobes(1);
        chk("t3_duty_max", int'(duty), 63);
        chk("t3_busy_low", int'(busy), 0);

        // 4: back to 0, then step=0 behaves as 1, then target==duty
        exp_duty_q.push_back(0); exp_done_q.push_back(0);
        do_start(0, 63, 0, 1'b0);
        strobes(1);
        exp_duty_q.push_back(1); exp_duty_q.push_back(2); exp_done_q.push_back(2);
        do_start(2, 0, 0, 1'b0);
        strobes(2);
        chk("t4_duty_step0", int'(duty), 2);
        exp_done_q.push_back(2);
        do_start(2, 5, 0, 1'b0);
        chk("t4_eq_busy", int'(busy), 0);
        chk("t4_eq_done", int'(done), 1);
        @(negedge clk);
        chk("t4_eq_busy_later", int'(busy), 0);
        chk("t4_eq_done_once", int'(done), 0);

        // 5: abort together with period_end, then start together with period_end
        exp_duty_q.push_back(6); exp_duty_q.push_back(10);
        do_start(50, 4, 0, 1'b0);
        strobes(2);
        @(negedge clk);
        abort = 1'b1; period_end = 1'b1;
        @(negedge clk);
        abort = 1'b0; period_end = 1'b0;
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_duty", int'(duty), 10);
        chk("t5_abort_done", int'(done), 0);
        strobes(1);
        chk("t5_abort_idle_hold", int'(duty), 10);
        do_start(50, 4, 0, 1'b1);
        chk("t5_restart_busy", int'(busy), 1);
        chk("t5_restart_no_move", int'(duty), 10);
        exp_duty_q.push_back(14); exp_duty_q.push_back(18);
        strobes(2);
        chk("t5_restart_moves", int'(duty), 18);

        // 6: asynchronous reset between edges mid-ramp
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_duty", int'(duty), 0);
        chk("t6_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobes(1);
        chk("t6_post_rst_duty", int'(duty), 0);
        chk("t6_post_rst_busy", int'(busy), 0);

        repeat (4) @(negedge clk);
        chk("duty_q_drained", exp_duty_q.size(), 0);
        chk("done_q_drained", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
